cpu_clock_sequencer: RTL and testbench

Generates the CPU's slow clock from the single high-frequency clock, along with a copy of it delayed by a fixed number of HF cycles and single-cycle edge strobes. Provides run, halt and single-step sequencing, so the CPU core can be free-run, stopped on a period boundary, or advanced one period at a time from the debug/front-panel logic. It replaces free-running dividers feeding the HF delay stage: the slow clock and its delayed copy are produced here, phase-locked, by one controller.

---
 rtl/cpu_clock_pkg.sv | 16 +
 rtl/clk_delay_line.sv | 38 +++
 rtl/cpu_clock_sequencer.sv | 116 +++++++++++
 tb/tb_cpu_clock_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clock_pkg.sv
// Shared types and default constants for the CPU clock sequencer.
//   state_e      : sequencer state (IDLE, RUN, STEP)
//   DEF_DIV_HALF : default HF cycles per half slow period
//   DEF_DELAY    : default HF-cycle lag of the delayed slow clock
package cpu_clock_pkg;

  localparam int unsigned DEF_DIV_HALF = 4;
  localparam int unsigned DEF_DELAY    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

endpackage

// File: rtl/clk_delay_line.sv
// DELAY-deep shift register producing a delayed copy of its input.
//   clk_i     : HF clock
//   rst_ni    : synchronous active-low clear
//   d_i       : bit shifted in every cycle
//   dly_o     : d_i delayed DELAY cycles (d_i itself when DELAY = 0)
//   any_nxt_o : any bit of the line will be set after the coming edge
module clk_delay_line #(
  parameter int unsigned DELAY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic dly_o,
  output logic any_nxt_o
);

  if (DELAY == 0) begin : g_bypass
    assign dly_o     = d_i;
    assign any_nxt_o = 1'b0;
  end else begin : g_line
    logic [DELAY-1:0] sr_q;
    logic [DELAY-1:0] sr_d;

    // Shift towards the MSB; truncation drops the bit leaving the line.
    always_comb begin
      sr_d = '0;
      if (rst_ni) sr_d = DELAY'({sr_q, d_i});
    end

    always_ff @(posedge clk_i) begin
      sr_q <= sr_d;
    end

    assign dly_o     = sr_q[DELAY-1];
    assign any_nxt_o = |sr_d;
  end

endmodule

// File: rtl/cpu_clock_sequencer.sv
// Slow CPU clock generator with run / halt / single-step sequencing.
//   i_CLK       : HF clock;  i_RST_N : synchronous active-low reset
//   i_RUN       : free-run request (level)
//   i_STEP      : one-period request (pulse, ignored unless idle)
//   o_CLK       : slow clock, high for the first DIV_HALF cycles of a period
//   o_CLK_DLY   : o_CLK delayed by DELAY HF cycles
//   o_RISE      : first cycle of each high phase
//   o_FALL      : first cycle of each low phase
//   o_BUSY      : sequencer active or delayed clock still draining
//   o_CYCLE_CNT : wrapping count of periods started
module cpu_clock_sequencer
  import cpu_clock_pkg::*;
#(
  parameter int unsigned DIV_HALF = DEF_DIV_HALF,
  parameter int unsigned DELAY    = DEF_DELAY,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_RUN,
  input  logic             i_STEP,
  output logic             o_CLK,
  output logic             o_CLK_DLY,
  output logic             o_RISE,
  output logic             o_FALL,
  output logic             o_BUSY,
  output logic [CNT_W-1:0] o_CYCLE_CNT
);

  localparam int unsigned PERIOD = 2 * DIV_HALF;
  localparam int unsigned CW     = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV_HALF);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             start;
  logic             dly_any_nxt;

  // Next-state: periods start from IDLE or at a wrap with i_RUN held.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_RUN) begin
          state_d = RUN;
          start   = 1'b1;
        end else if (i_STEP) begin
          state_d = STEP;
          start   = 1'b1;
        end
      end
      default: begin
        if (cnt_q == LAST) begin
          if (i_RUN) begin
            state_d = RUN;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    cnt_d  = (state_q != IDLE && cnt_q != LAST) ? cnt_q + CW'(1) : '0;
    cyc_d  = start ? cyc_q + CNT_W'(1) : cyc_q;
    clk_d  = (state_d != IDLE) && (cnt_d < HALF);
    rise_d = clk_d & ~clk_q;
    fall_d = ~clk_d & clk_q;
    busy_d = (state_d != IDLE) | dly_any_nxt;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Fed by the registered slow clock so the lag is exact in HF cycles.
  clk_delay_line #(
    .DELAY (DELAY)
  ) u_dly (
    .clk_i     (i_CLK),
    .rst_ni    (i_RST_N),
    .d_i       (clk_q),
    .dly_o     (o_CLK_DLY),
    .any_nxt_o (dly_any_nxt)
  );

  assign o_CLK       = clk_q;
  assign o_RISE      = rise_q;
  assign o_FALL      = fall_q;
  assign o_BUSY      = busy_q;
  assign o_CYCLE_CNT = cyc_q;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Directed bench for cpu_clock_sequencer with DIV_HALF=4, DELAY=2.
module tb_cpu_clock_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        o_clk;
  logic        o_dly;
  logic        o_rise;
  logic        o_fall;
  logic        o_busy;
  logic [15:0] o_cnt;

  int          checks;
  int          errors;
  logic [15:0] exp_cnt;

  cpu_clock_sequencer #(
    .DIV_HALF (4),
    .DELAY    (2),
    .CNT_W    (16)
  ) dut (
    .i_CLK       (clk),
    .i_RST_N     (rst_n),
    .i_RUN       (run),
    .i_STEP      (step),
    .o_CLK       (o_clk),
    .o_CLK_DLY   (o_dly),
    .o_RISE      (o_rise),
    .o_FALL      (o_fall),
    .o_BUSY      (o_busy),
    .o_CYCLE_CNT (o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waveform of one isolated period whose start edge is k=0.
  function automatic logic [4:0] single_vec(input int k);
    single_vec = {k < 4, (k >= 2) && (k < 6), k == 0, k == 4, k < 8};
  endfunction

  // Waveform of a free-running sequence whose first start edge is k=0.
  function automatic logic [4:0] run_vec(input int k);
    run_vec = {(k % 8) < 4, (k >= 2) && (((k - 2) % 8) < 4),
               (k % 8) == 0, (k % 8) == 4, 1'b1};
  endfunction

  task automatic drain(input string name);
    run = 1'b0;
    for (int i = 0; i < 40 && o_busy; i++) tick();
    checks++;
    if ({o_busy, o_clk, o_dly} !== 3'b000 || o_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s_drain busy/clk/dly=%b cnt=%h exp 000 cnt=%h",
               name, {o_busy, o_clk, o_dly}, o_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b1;
    step  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o_clk, o_dly, o_rise, o_fall, o_busy} !== 5'b0 || o_cnt !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold i=%0d got %b cnt=%h exp 00000 cnt=0000",
                 i, {o_clk, o_dly, o_rise, o_fall, o_busy}, o_cnt);
      end
    end
    rst_n = 1'b1;
    tick();
    exp_cnt = 16'd1;
    checks++;
    if ({o_clk, o_dly, o_rise, o_fall, o_busy} !== 5'b10101 || o_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL reset_first_rise got %b cnt=%h exp 10101 cnt=%h",
               {o_clk, o_dly, o_rise, o_fall, o_busy}, o_cnt, exp_cnt);
    end
    drain("reset");
  endtask

  task automatic test_free_run();
    logic [15:0] base;
    base = exp_cnt;
    run  = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      checks++;
      if ({o_clk, o_dly, o_rise, o_fall, o_busy} !== run_vec(k) ||
          o_cnt !== base + 16'(k / 8 + 1)) begin
        errors++;
        $display("FAIL free_run k=%0d got %b cnt=%h exp %b cnt=%h", k,
                 {o_clk, o_dly, o_rise, o_fall, o_busy}, o_cnt, run_vec(k),
                 base + 16'(k / 8 + 1));
      end
    end
    exp_cnt = base + 16'd3;
    drain("free_run");
  endtask

  task automatic test_step();
    logic [15:0] base;
    base = exp_cnt;
    step = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      step = 1'b0;
      checks++;
      if ({o_clk, o_dly, o_rise, o_fall, o_busy} !== single_vec(k) ||
          o_cnt !== base + 16'd1) begin
        errors++;
        $display("FAIL step k=%0d got %b cnt=%h exp %b cnt=%h", k,
                 {o_clk, o_dly, o_rise, o_fall, o_busy}, o_cnt, single_vec(k),
                 base + 16'd1);
      end
    end
    exp_cnt = base + 16'd1;
    drain("step");
  endtask

  task automatic test_halt();
    logic [15:0] base;
    base = exp_cnt;
    run  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 2) run = 1'b0;
      checks++;
      if ({o_clk, o_dly, o_rise, o_fall, o_busy} !== single_vec(k) ||
          o_cnt !== base + 16'd1) begin
        errors++;
        $display("FAIL halt k=%0d got %b cnt=%h exp %b cnt=%h", k,
                 {o_clk, o_dly, o_rise, o_fall, o_busy}, o_cnt, single_vec(k),
                 base + 16'd1);
      end
    end
    exp_cnt = base + 16'd1;
    drain("halt");
  endtask

  task automatic test_simultaneous();
    logic [15:0] base;
    base = exp_cnt;
    run  = 1'b1;
    step = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      // A step pulse in the middle of the run must be ignored.
      step = (k == 2);
      checks++;
      if ({o_clk, o_dly, o_rise, o_fall, o_busy} !== run_vec(k) ||
          o_cnt !== base + 16'(k / 8 + 1)) begin
        errors++;
        $display("FAIL simultaneous k=%0d got %b cnt=%h exp %b cnt=%h", k,
                 {o_clk, o_dly, o_rise, o_fall, o_busy}, o_cnt, run_vec(k),
                 base + 16'(k / 8 + 1));
      end
    end
    exp_cnt = base + 16'd2;
    drain("simultaneous");
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_cnt = 16'd0;
    checks++;
    if ({o_clk, o_dly, o_rise, o_fall, o_busy} !== 5'b0 || o_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL reset_mid got %b cnt=%h exp 00000 cnt=0000",
               {o_clk, o_dly, o_rise, o_fall, o_busy}, o_cnt);
    end
    rst_n = 1'b1;
    run   = 1'b0;
    tick();
    checks++;
    if ({o_clk, o_dly, o_rise, o_fall, o_busy} !== 5'b0 || o_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL reset_mid_release got %b cnt=%h exp 00000 cnt=0000",
               {o_clk, o_dly, o_rise, o_fall, o_busy}, o_cnt);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 16'd0;
    rst_n   = 1'b0;
    run     = 1'b0;
    step    = 1'b0;
    test_reset();
    test_free_run();
    test_step();
    test_halt();
    test_simultaneous();
    test_reset_mid();
    test_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
